// File: rtl/path_tracker_if.sv
// rtl/path_tracker_if.sv - command, pop and replay-stream bundle for path_tracker
//
// Purpose: groups the walker-facing command inputs, the pop result, the stack
// status and the replay location stream into one bundle.
//   master modport: the walker / consumer side (drives push/pop/replay inputs)
//   slave modport : path_tracker itself
// Signals:
//   push, pushDir          record a committed move
//   pop, popDir, popValid  backtrack one move, inverse direction returned
//   count, full, empty     stack occupancy
//   replayStart, startLoc  begin replaying the stored path from a start cell
//   rpLoc, rpValid, rpReady, rpLast, rpDone   replay location stream
//   busy, err              replay in progress, sticky illegal-operation flag
interface path_tracker_if #(
    parameter int AW = 7
);
    logic          push;
    logic [1:0]    pushDir;
    logic          pop;
    logic [1:0]    popDir;
    logic          popValid;
    logic [AW-1:0] count;
    logic          full;
    logic          empty;
    logic          replayStart;
    logic [7:0]    startLoc;
    logic [7:0]    rpLoc;
    logic          rpValid;
    logic          rpReady;
    logic          rpLast;
    logic          rpDone;
    logic          busy;
    logic          err;

    modport master (
        output push, pushDir, pop, replayStart, startLoc, rpReady,
        input  popDir, popValid, count, full, empty,
        input  rpLoc, rpValid, rpLast, rpDone, busy, err
    );

    modport slave (
        input  push, pushDir, pop, replayStart, startLoc, rpReady,
        output popDir, popValid, count, full, empty,
        output rpLoc, rpValid, rpLast, rpDone, busy, err
    );
endinterface

// File: rtl/path_tracker.sv
// rtl/path_tracker.sv - move stack with backtrack and path replay for the maze walker
//
// Purpose: records committed 2-bit moves on a stack, returns the inverse of the
// top move on pop, and replays the stored path as a stream of {X,Y} locations.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (aborts a replay, empties the stack)
//   bus  - path_tracker_if.slave (commands, pop result, status, replay stream)
// Direction encoding: 00 = Y-1, 01 = X+1, 10 = X-1, 11 = Y+1.
// Optional feature: define PATH_TRACKER_ERR_EN to build the sticky err flag;
// without it err is tied low and illegal operations are only ignored.
module path_tracker #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    path_tracker_if.slave bus
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REPLAY = 1'b1;

    // Array index width; count itself needs one more value (DEPTH) than the
    // array has entries, so indices are taken from its low bits.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [0:0]    state;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] cnt;
    logic [AW-1:0] rp_idx;
    logic [1:0]    pop_dir;
    logic          pop_valid;
    logic          rp_done;
    logic [7:0]    rp_loc;

    logic          in_idle;
    logic          in_replay;
    logic          is_full;
    logic          is_empty;
    logic [AW-1:0] cnt_m1;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;
    logic          rp_last;

    // One step of the walker in the shared location format. Each axis is a
    // 4-bit modulo-16 counter; no carry crosses between X and Y.
    function automatic logic [7:0] step_loc(input logic [7:0] loc, input logic [1:0] dir);
        logic [3:0] x;
        logic [3:0] y;
        x = loc[7:4];
        y = loc[3:0];
        if (^dir) begin
            x = dir[0] ? (x + 4'd1) : (x - 4'd1);
        end else begin
            y = dir[0] ? (y + 4'd1) : (y - 4'd1);
        end
        return {x, y};
    endfunction

    assign in_idle   = (state == S_IDLE);
    assign in_replay = (state == S_REPLAY);
    assign is_full   = (cnt == AW'(DEPTH));
    assign is_empty  = (cnt == '0);
    assign cnt_m1    = cnt - AW'(1);
    assign wr_idx    = cnt[IW-1:0];
    assign top_idx   = cnt_m1[IW-1:0];
    assign rd_idx    = rp_idx[IW-1:0];

    // A simultaneous push and pop keeps the pop and drops the push.
    assign do_pop  = in_idle && bus.pop && !is_empty;
    assign do_push = in_idle && bus.push && !bus.pop && !is_full;

    // The final beat is the one at index count; compared live so a replay
    // started on the same edge as a push/pop sees the updated depth.
    assign rp_last = in_replay && (rp_idx == cnt);

    // Move storage carries no reset: entries above count are never read.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_idx] <= bus.pushDir;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rp_idx    <= '0;
            pop_dir   <= 2'b00;
            pop_valid <= 1'b0;
            rp_done   <= 1'b0;
            rp_loc    <= 8'h00;
        end else begin
            pop_valid <= 1'b0;
            rp_done   <= 1'b0;
            if (in_idle) begin
                if (do_pop) begin
                    pop_dir   <= ~mem[top_idx];
                    pop_valid <= 1'b1;
                    cnt       <= cnt_m1;
                end else if (do_push) begin
                    cnt <= cnt + AW'(1);
                end
                if (bus.replayStart) begin
                    state  <= S_REPLAY;
                    rp_idx <= '0;
                    rp_loc <= bus.startLoc;
                end
            end else begin
                // rpValid is high for the whole of REPLAY, so rpReady alone
                // marks an accepted beat.
                if (bus.rpReady) begin
                    if (rp_last) begin
                        state   <= S_IDLE;
                        rp_done <= 1'b1;
                    end else begin
                        rp_loc <= step_loc(rp_loc, mem[rd_idx]);
                        rp_idx <= rp_idx + AW'(1);
                    end
                end
            end
        end
    end

`ifdef PATH_TRACKER_ERR_EN
    logic illegal;
    logic err_q;

    // Anything the block has to ignore counts as illegal: any command while
    // replaying, and in IDLE a push/pop collision, overflow or underflow.
    always_comb begin
        illegal = 1'b0;
        if (in_replay) begin
            illegal = bus.push || bus.pop || bus.replayStart;
        end else begin
            illegal = (bus.push && bus.pop)
                   || (bus.push && !bus.pop && is_full)
                   || (bus.pop && is_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (illegal) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.count    = cnt;
    assign bus.full     = is_full;
    assign bus.empty    = is_empty;
    assign bus.popDir   = pop_dir;
    assign bus.popValid = pop_valid;
    assign bus.rpLoc    = rp_loc;
    assign bus.rpValid  = in_replay;
    assign bus.rpLast   = rp_last;
    assign bus.rpDone   = rp_done;
    assign bus.busy     = in_replay;

endmodule

// File: tb/tb_path_tracker.sv
// tb/tb_path_tracker.sv - self-checking bench for path_tracker
module tb_path_tracker;

    localparam int DEPTH = 4;
    localparam int AW    = 3;
`ifdef PATH_TRACKER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    path_tracker_if #(.AW(AW)) bus ();

    path_tracker #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: the stack as a queue of directions plus a sticky error bit.
    logic [1:0] m_stk[$];
    bit         m_err;
    logic [1:0] last_pd;

    typedef struct {
        bit         push;
        logic [1:0] dir;
        bit         pop;
        int         cnt;
        bit         pv;
        logic [1:0] pd;
        bit         full;
        bit         empty;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inverse move: the opposite step on the same axis.
    function automatic logic [1:0] inv_dir(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b11;
            2'b11:   return 2'b00;
            2'b01:   return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"},  bus.count, 0);
        chk({tag, "_empty"},  bus.empty, 1);
        chk({tag, "_full"},   bus.full, 0);
        chk({tag, "_popdir"}, bus.popDir, 0);
        chk({tag, "_popval"}, bus.popValid, 0);
        chk({tag, "_rploc"},  bus.rpLoc, 0);
        chk({tag, "_rpval"},  bus.rpValid, 0);
        chk({tag, "_rplast"}, bus.rpLast, 0);
        chk({tag, "_rpdone"}, bus.rpDone, 0);
        chk({tag, "_busy"},   bus.busy, 0);
        chk({tag, "_err"},    bus.err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.push = 0; bus.pop = 0; bus.replayStart = 0; bus.rpReady = 0;
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        m_stk.delete();
        m_err = 0;
    endtask

    // One IDLE cycle of push/pop, checked against the model.
    task automatic cyc(input bit p, input logic [1:0] d, input bit q);
        bit exp_pv;
        bus.push = p; bus.pushDir = d; bus.pop = q;
        tick();
        bus.push = 0; bus.pop = 0;
        exp_pv = 0;
        if (q) begin
            if (m_stk.size() > 0) begin
                last_pd = inv_dir(m_stk[$]);
                void'(m_stk.pop_back());
                exp_pv = 1;
            end else begin
                m_err = 1;
            end
            if (p) m_err = 1;
        end else if (p) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(d);
            else m_err = 1;
        end
        chk("count", bus.count, m_stk.size());
        chk("full", bus.full, m_stk.size() == DEPTH);
        chk("empty", bus.empty, m_stk.size() == 0);
        chk("pop_valid", bus.popValid, exp_pv);
        if (exp_pv) chk("pop_dir", bus.popDir, last_pd);
        chk("err", bus.err, ERR_EN ? m_err : 1'b0);
        chk("busy_idle", bus.busy, 0);
    endtask

    // Full replay. stall_beat/stall_len hold rpReady low on one beat (with a
    // push thrown in on the first stalled cycle); rnd randomizes rpReady and
    // sprays commands that must all be ignored.
    task automatic do_replay(input logic [7:0] start, input int stall_beat,
                             input int stall_len, input bit rnd);
        logic [7:0] exp[$];
        int x, y, b, guard, stalled;
        bit rdy;
        x = int'(start[7:4]);
        y = int'(start[3:0]);
        exp.push_back(start);
        foreach (m_stk[k]) begin
            case (m_stk[k])
                2'b00: y = (y + 15) % 16;
                2'b01: x = (x + 1) % 16;
                2'b10: x = (x + 15) % 16;
                default: y = (y + 1) % 16;
            endcase
            exp.push_back(8'(x * 16 + y));
        end
        bus.replayStart = 1; bus.startLoc = start; bus.rpReady = 0;
        tick();
        bus.replayStart = 0;
        chk("busy_rise", bus.busy, 1);
        chk("rpvalid_rise", bus.rpValid, 1);
        b = 0; guard = 0; stalled = 0;
        while (b < exp.size() && guard < 200) begin
            bus.push = 0; bus.pop = 0; bus.replayStart = 0;
            if (rnd) begin
                rdy = ($urandom_range(0, 1) == 1);
                bus.push = ($urandom_range(0, 3) == 0);
                bus.pushDir = 2'($urandom_range(0, 3));
                bus.pop = ($urandom_range(0, 3) == 0);
                bus.replayStart = ($urandom_range(0, 5) == 0);
                bus.startLoc = 8'($urandom_range(0, 255));
                if (bus.push || bus.pop || bus.replayStart) m_err = 1;
            end else begin
                rdy = !(b == stall_beat && stalled < stall_len);
                if (!rdy && stalled == 0) begin
                    bus.push = 1; bus.pushDir = 2'b10;
                    m_err = 1;
                end
            end
            bus.rpReady = rdy;
            chk("rp_valid", bus.rpValid, 1);
            chk("rp_loc", bus.rpLoc, exp[b]);
            chk("rp_last", bus.rpLast, b == exp.size() - 1);
            if (rdy) b++;
            else stalled++;
            tick();
            guard++;
        end
        bus.push = 0; bus.pop = 0; bus.replayStart = 0; bus.rpReady = 0;
        if (guard >= 200) chk("replay_timeout", 1, 0);
        chk("rp_valid_drop", bus.rpValid, 0);
        chk("busy_drop", bus.busy, 0);
        chk("rp_done", bus.rpDone, 1);
        chk("count_after_replay", bus.count, m_stk.size());
        chk("err_after_replay", bus.err, ERR_EN ? m_err : 1'b0);
        tick();
        chk("rp_done_pulse", bus.rpDone, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        clk = 0; rst = 1;
        bus.push = 0; bus.pushDir = 0; bus.pop = 0;
        bus.replayStart = 0; bus.startLoc = 0; bus.rpReady = 0;
        m_err = 0; last_pd = 0;

        //            push dir   pop cnt pv pd    full empty
        tbl[0]  = '{1, 2'b01, 0, 1, 0, 2'b00, 0, 0};
        tbl[1]  = '{1, 2'b01, 0, 2, 0, 2'b00, 0, 0};
        tbl[2]  = '{1, 2'b11, 0, 3, 0, 2'b00, 0, 0};
        tbl[3]  = '{0, 2'b00, 1, 2, 1, 2'b00, 0, 0};
        tbl[4]  = '{1, 2'b10, 0, 3, 0, 2'b00, 0, 0};
        tbl[5]  = '{1, 2'b00, 0, 4, 0, 2'b00, 1, 0};
        tbl[6]  = '{1, 2'b11, 0, 4, 0, 2'b00, 1, 0};
        tbl[7]  = '{0, 2'b00, 1, 3, 1, 2'b11, 0, 0};
        tbl[8]  = '{1, 2'b11, 1, 2, 1, 2'b01, 0, 0};
        tbl[9]  = '{0, 2'b00, 0, 2, 0, 2'b00, 0, 0};
        tbl[10] = '{0, 2'b00, 1, 1, 1, 2'b10, 0, 0};
        tbl[11] = '{0, 2'b00, 1, 0, 1, 2'b10, 0, 1};
        tbl[12] = '{0, 2'b00, 1, 0, 0, 2'b00, 0, 1};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].push, tbl[i].dir, tbl[i].pop);
            chk($sformatf("tbl%0d_count", i), bus.count, tbl[i].cnt);
            chk($sformatf("tbl%0d_popvalid", i), bus.popValid, tbl[i].pv);
            if (tbl[i].pv) chk($sformatf("tbl%0d_popdir", i), bus.popDir, tbl[i].pd);
            chk($sformatf("tbl%0d_full", i), bus.full, tbl[i].full);
            chk($sformatf("tbl%0d_empty", i), bus.empty, tbl[i].empty);
        end
        chk("tbl_err_sticky", bus.err, ERR_EN);

        // Recorded path replay, then pops of the same path.
        do_reset();
        cyc(1, 2'b01, 0); cyc(1, 2'b01, 0); cyc(1, 2'b11, 0);
        do_replay(8'h00, -1, 0, 0);
        chk("path_count_kept", bus.count, 3);
        cyc(0, 2'b00, 1);
        chk("pop1_dir", bus.popDir, 2'b00);
        chk("pop1_count", bus.count, 2);
        cyc(0, 2'b00, 0);
        chk("pop1_pulse", bus.popValid, 0);
        cyc(0, 2'b00, 1);
        chk("pop2_dir", bus.popDir, 2'b10);
        cyc(0, 2'b00, 1);
        chk("pop3_dir", bus.popDir, 2'b10);

        // Axis wrap.
        do_reset();
        cyc(1, 2'b01, 0); cyc(1, 2'b00, 0);
        do_replay(8'hF0, -1, 0, 0);

        // Overflow with five pushes, underflow after reset.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 2'(i), 0);
        chk("ovf_count", bus.count, 4);
        chk("ovf_full", bus.full, 1);
        chk("ovf_err", bus.err, ERR_EN);
        do_reset();
        cyc(0, 2'b00, 1);
        chk("udf_popvalid", bus.popValid, 0);
        chk("udf_count", bus.count, 0);

        // Backpressure on the second beat, with a push during replay.
        do_reset();
        cyc(1, 2'b01, 0); cyc(1, 2'b01, 0); cyc(1, 2'b11, 0);
        do_replay(8'h00, 1, 3, 0);
        chk("bp_count", bus.count, 3);

        // Reset mid-replay.
        do_reset();
        cyc(1, 2'b01, 0); cyc(1, 2'b11, 0);
        bus.replayStart = 1; bus.startLoc = 8'h35; bus.rpReady = 1;
        tick();
        bus.replayStart = 0;
        chk("mid_beat0", bus.rpLoc, 8'h35);
        tick();
        chk("mid_beat1", bus.rpLoc, 8'h45);
        rst = 1;
        tick();
        check_reset_outputs("mid_reset");
        rst = 0;
        bus.rpReady = 0;
        m_stk.delete();
        m_err = 0;
        do_replay(8'h35, -1, 0, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_replay(8'($urandom_range(0, 255)), -1, 0, 1);
            end else begin
                cyc($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
